hazard_ctrl: RTL
================

Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage WISC pipeline.
- Tracks the destination registers of in-flight instructions in a small shift pipe.
- Compares the decode-stage sources against those pending writes and drives haz_stall back into decode_instr, together with PC/IF-ID hold and squash controls.
- Also sequences control-flow flushes, memory-busy freezes and the halt latch.

Parameters:
- PIPE_DEPTH, 3, number of tracked stages past decode (EX, MEM, WB).
- RF_BYPASS, 1, when 1 the register file is write-before-read, so the WB (last) entry is excluded from compares.
- FLUSH_CYCLES, 2, cycles of IF/ID squash after a redirect.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- instr_valid  in  1  decode holds a real instruction (not a bubble).
- Rs  in  3  decode source register 1.
- Rt  in  3  decode source register 2.
- rs_used  in  1  instruction reads Rs.
- rt_used  in  1  instruction reads Rt.
- Rd  in  3  decode destination register.
- reg_write_dec  in  1  decode would write Rd (ungated by haz_stall).
- halt_dec  in  1  decode sees HALT.
- redirect  in  1  taken branch/jump resolved this cycle.
- mem_stall  in  1  data/instruction memory busy; freeze whole pipe.
- haz_stall  out  1  inject bubble into ID/EX, hold decode.
- pc_hold  out  1  hold PC and IF/ID.
- flush_if  out  1  squash IF/ID contents.
- halted  out  1  processor halted (sticky).

Behaviour:
- Single clock domain.
- Reset is synchronous and active-high: on a rst=1 clock edge, all pipe entries become invalid, flush_cnt=0 and halted=0.
- While rst=1, all outputs are forced to 0 combinationally.
- Pipe entry format: {valid, rd[2:0]}. entry[0] is EX, entry[PIPE_DEPTH-1] is WB.
- Compare set: entries 0..PIPE_DEPTH-1-RF_BYPASS.
- match = instr_valid & ((rs_used & hit(Rs)) | (rt_used & hit(Rt))), where hit(r) = any valid compared entry with rd==r. All 8 registers, including R0, are treated alike.
- flush_active = (flush_cnt != 0) | redirect.
- haz_stall = match & ~flush_active & ~halted. Redirect has priority: a squashed instruction never stalls.
- pc_hold = haz_stall | mem_stall | halted.
- flush_if = flush_active & ~mem_stall.
- Pipe update per edge:
  - mem_stall=1: freeze all entries and flush_cnt. This overrides everything except rst.
  - Otherwise: entry[i] <= entry[i-1] for i ≥ 1.
  - entry[0] <= {reg_write_dec & instr_valid & ~haz_stall & ~flush_active & ~halted, Rd}.
- Flush counter:
  - redirect & ~mem_stall loads flush_cnt = FLUSH_CYCLES-1.
  - Otherwise it decrements when nonzero and ~mem_stall.
  - A redirect during an active flush reloads the counter; it does not extend by addition.
- Latency:
  - haz_stall is combinational, same cycle as the decode inputs.
  - A stall clears no later than the cycle after the producer leaves the last compared stage. With default parameters this is at most 2 stall cycles on a back-to-back dependency.
- Halt:
  - halted sets on the edge where halt_dec & instr_valid & ~haz_stall & ~flush_active & ~mem_stall.
  - halted is sticky until rst.
  - Older entries continue draining while halted.
- Simultaneous events:
  - rst beats everything.
  - mem_stall beats redirect for state update.
  - redirect beats haz_stall.
  - A squashed HALT does not set halted.
- No backpressure or handshake beyond mem_stall. The block never deadlocks because entries always drain when mem_stall=0.

Decomposition:
- Shared package hazard_pkg holds:
  - REG_W=3.
  - Typedef dest_entry_t {valid, rd}.
  - Default constants PIPE_DEPTH/FLUSH_CYCLES.
  - Function reg_hit(entry, r).
- One sub-module, hazard_dest_pipe: the parameterized shift register with a freeze input and per-entry valid/rd outputs.
- Compare logic, flush counter and halt latch stay in hazard_ctrl.

Test Plan:
- RAW back-to-back: ADD R1 writes R1, next instruction reads Rs=1 -> haz_stall=1 for 2 cycles, pc_hold=1, then 0. Exactly 2 bubbles enter entry[0] with valid=0.
- Distance 3 with RF_BYPASS=1: producer, two independent instructions, consumer Rt=1 -> haz_stall never asserts. Repeat with RF_BYPASS=0 -> 1 stall cycle.
- Unused source: consumer has rs_used=0 with Rs=1 pending -> no stall. Store reading Rt=1 with rt_used=1 -> stall.
- Redirect during stall: pending match and redirect=1 in the same cycle -> haz_stall=0, flush_if=1 for 2 cycles, entry[0] loaded invalid.
- mem_stall=1 for 3 cycles mid-dependency -> entries and stall count frozen, pc_hold=1. Stall resumes with the same remaining count afterward.
- HALT then rst: halt_dec accepted -> halted=1, pc_hold=1 and no new valid entries. rst=1 for 1 cycle -> all outputs 0 and entries invalid on the next cycle.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and defaults for the WISC pipeline hazard controller.
package hazard_pkg;

  localparam int REG_W            = 3;
  localparam int PIPE_DEPTH_DEF   = 3;
  localparam int FLUSH_CYCLES_DEF = 2;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
  } dest_entry_t;

  function automatic logic reg_hit(dest_entry_t e, logic [REG_W-1:0] r);
    return e.valid && (e.rd == r);
  endfunction

endpackage

// File: rtl/hazard_dest_pipe.sv
// Shift pipe of in-flight destination registers; entry 0 is EX, the last entry is WB.
module hazard_dest_pipe
  import hazard_pkg::*;
#(
  parameter int DEPTH = PIPE_DEPTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_freeze,
  input  logic                   i_valid,
  input  logic [REG_W-1:0]       i_rd,
  output logic [DEPTH-1:0]       o_valid,
  output logic [DEPTH*REG_W-1:0] o_rd
);

  dest_entry_t r_pipe [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_pipe[i] <= '0;
    end else if (!i_freeze) begin
      r_pipe[0] <= {i_valid, i_rd};
      for (int i = 1; i < DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  always_comb begin
    o_valid = '0;
    o_rd    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      o_valid[i]               = r_pipe[i].valid;
      o_rd[i*REG_W +: REG_W]   = r_pipe[i].rd;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller: RAW stall detection against pending writes, redirect flush
// sequencing, memory-busy freeze and the sticky halt latch.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int PIPE_DEPTH   = PIPE_DEPTH_DEF,
  parameter int RF_BYPASS    = 1,
  parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             instr_valid,
  input  logic [REG_W-1:0] Rs,
  input  logic [REG_W-1:0] Rt,
  input  logic             rs_used,
  input  logic             rt_used,
  input  logic [REG_W-1:0] Rd,
  input  logic             reg_write_dec,
  input  logic             halt_dec,
  input  logic             redirect,
  input  logic             mem_stall,
  output logic             haz_stall,
  output logic             pc_hold,
  output logic             flush_if,
  output logic             halted
);

  localparam int CMP_N = PIPE_DEPTH - RF_BYPASS;
  localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_CYCLES - 1);

  logic [CNT_W-1:0]            r_flush_cnt;
  logic                        r_halted;
  logic [PIPE_DEPTH-1:0]       w_pipe_valid;
  logic [PIPE_DEPTH*REG_W-1:0] w_pipe_rd;
  dest_entry_t                 w_ent [PIPE_DEPTH];
  logic w_hit_rs, w_hit_rt, w_match, w_flush_active, w_stall, w_accept;
  logic w_push_valid, w_halt_set;

  hazard_dest_pipe #(.DEPTH(PIPE_DEPTH)) u_dest_pipe (
    .clk      (clk),
    .rst      (rst),
    .i_freeze (mem_stall),
    .i_valid  (w_push_valid),
    .i_rd     (Rd),
    .o_valid  (w_pipe_valid),
    .o_rd     (w_pipe_rd)
  );

  // With a write-before-read register file the WB entry is already visible to decode.
  always_comb begin
    w_hit_rs = 1'b0;
    w_hit_rt = 1'b0;
    for (int i = 0; i < PIPE_DEPTH; i++) begin
      w_ent[i] = {w_pipe_valid[i], w_pipe_rd[i*REG_W +: REG_W]};
      if (i < CMP_N) begin
        w_hit_rs = w_hit_rs | reg_hit(w_ent[i], Rs);
        w_hit_rt = w_hit_rt | reg_hit(w_ent[i], Rt);
      end
    end
  end

  assign w_match        = instr_valid & ((rs_used & w_hit_rs) | (rt_used & w_hit_rt));
  assign w_flush_active = (r_flush_cnt != '0) | redirect;
  assign w_stall        = w_match & ~w_flush_active & ~r_halted;
  assign w_accept       = instr_valid & ~w_stall & ~w_flush_active & ~r_halted;
  assign w_push_valid   = reg_write_dec & w_accept;
  assign w_halt_set     = halt_dec & w_accept & ~mem_stall;

  assign haz_stall = ~rst & w_stall;
  assign pc_hold   = ~rst & (w_stall | mem_stall | r_halted);
  assign flush_if  = ~rst & w_flush_active & ~mem_stall;
  assign halted    = ~rst & r_halted;

  // A redirect during an active flush restarts the window rather than extending it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_flush_cnt <= '0;
      r_halted    <= 1'b0;
    end else begin
      if (!mem_stall) begin
        if (redirect)                r_flush_cnt <= CNT_LOAD;
        else if (r_flush_cnt != '0)  r_flush_cnt <= r_flush_cnt - 1'b1;
      end
      if (w_halt_set) r_halted <= 1'b1;
    end
  end

endmodule
